cim_job_ctrl: RTL and testbench

- Sequences the CIM macro for one job at a time. A job is one weight load followed by cfg_len IFM vectors.
- Upstream is a valid/ready IFM stream. Downstream is a valid/ready result stream with last tagging.
- The CIM macro has no stall input, so a credit counter limits in-flight vectors plus buffered results to the result FIFO depth. Results therefore never drop.
- Sits between the feature-map buffer and the CIM core at the top level.

---
 rtl/cim_pkg.sv | 17 +
 rtl/cim_res_fifo.sv | 51 +++++
 rtl/cim_job_ctrl.sv | 148 ++++++++++++++
 tb/tb_cim_job_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cim_pkg.sv
// Shared sizes and controller state encoding for the CIM job sequencer.
package cim_pkg;

  localparam int unsigned N_LANE = 32;
  localparam int unsigned W_BITS = 4;
  localparam int unsigned OFM_W  = 13;
  localparam int unsigned VEC_W  = N_LANE * W_BITS;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StGap,
    StStream,
    StDrain
  } state_e;

endpackage

// File: rtl/cim_res_fifo.sv
// Result FIFO between the CIM output and the downstream result stream.
module cim_res_fifo #(
  parameter int unsigned Width = 13,
  parameter int unsigned Depth = 4,
  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             full, do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty_o;
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/cim_job_ctrl.sv
// Job sequencer for the CIM macro: weight load, settle gap, credit-limited
// IFM streaming and result buffering with last tagging.
module cim_job_ctrl
  import cim_pkg::*;
#(
  parameter int unsigned CIM_LAT  = 1,
  parameter int unsigned RF_DEPTH = 4,
  parameter int unsigned LEN_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [VEC_W-1:0] cfg_weight,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             ifm_valid,
  output logic             ifm_ready,
  input  logic [VEC_W-1:0] ifm_data,
  output logic             cim_weight_valid,
  output logic [VEC_W-1:0] cim_Weight,
  output logic             cim_in_valid,
  output logic [VEC_W-1:0] cim_IFM,
  input  logic             cim_out_valid,
  input  logic [OFM_W-1:0] cim_OFM,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [OFM_W-1:0] res_data,
  output logic             res_last,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned CNT_W = $clog2(RF_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  if (RF_DEPTH < CIM_LAT + 1) begin : g_depth_check
    $error("RF_DEPTH must cover the CIM pipeline plus one result");
  end

  state_e           state_q, state_d;
  logic [VEC_W-1:0] weight_q, ifm_q;
  logic             in_valid_q, err_q;
  logic [LEN_W-1:0] len_rem_q, len_rem_d, res_rem_q, res_rem_d;
  logic [CNT_W-1:0] inflight_q, inflight_d, fifo_count;
  logic [SUM_W-1:0] occupancy;
  logic [OFM_W-1:0] fifo_head;
  logic             fifo_empty, cfg_hs, ifm_hs, res_hs, ret_ok, ret_bad;

  // Credit: in-flight vectors plus buffered results never exceed the FIFO.
  assign occupancy = SUM_W'(inflight_q) + SUM_W'(fifo_count);

  assign cfg_ready = (state_q == StIdle);
  assign ifm_ready = (state_q == StStream) && (occupancy < SUM_W'(RF_DEPTH));
  assign cfg_hs    = cfg_valid && cfg_ready;
  assign ifm_hs    = ifm_valid && ifm_ready;
  assign ret_ok    = cim_out_valid && (inflight_q != '0);
  assign ret_bad   = cim_out_valid && (inflight_q == '0);

  assign res_valid = !fifo_empty;
  assign res_data  = res_valid ? fifo_head : '0;
  assign res_last  = res_valid && (res_rem_q == LEN_W'(1));
  assign res_hs    = res_valid && res_ready;

  assign cim_weight_valid = (state_q == StLoad);
  assign cim_Weight       = weight_q;
  assign cim_in_valid     = in_valid_q;
  assign cim_IFM          = ifm_q;
  assign busy             = (state_q != StIdle);
  assign err              = err_q;

  always_comb begin
    state_d   = state_q;
    len_rem_d = len_rem_q;
    done      = 1'b0;
    case (state_q)
      StIdle:  if (cfg_valid) state_d = StLoad;
      StLoad:  state_d = StGap;
      StGap:   state_d = (len_rem_q == '0) ? StDrain : StStream;
      StStream: begin
        if (ifm_hs) begin
          len_rem_d = len_rem_q - 1'b1;
          if (len_rem_q == LEN_W'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        if (res_rem_q == '0) begin
          state_d = StIdle;
          done    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (cfg_hs) len_rem_d = cfg_len;
  end

  always_comb begin
    res_rem_d = res_rem_q;
    if (cfg_hs) begin
      res_rem_d = cfg_len;
    end else if (res_hs && (res_rem_q != '0)) begin
      res_rem_d = res_rem_q - 1'b1;
    end
    inflight_d = inflight_q;
    case ({ifm_hs, ret_ok})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      weight_q   <= '0;
      ifm_q      <= '0;
      in_valid_q <= 1'b0;
      len_rem_q  <= '0;
      res_rem_q  <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_rem_q  <= len_rem_d;
      res_rem_q  <= res_rem_d;
      inflight_q <= inflight_d;
      in_valid_q <= ifm_hs;
      err_q      <= err_q | ret_bad;
      if (cfg_hs) weight_q <= cfg_weight;
      if (ifm_hs) ifm_q <= ifm_data;
    end
  end

  cim_res_fifo #(
    .Width(OFM_W),
    .Depth(RF_DEPTH)
  ) u_res_fifo (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .push_i (ret_ok),
    .wdata_i(cim_OFM),
    .pop_i  (res_hs),
    .rdata_o(fifo_head),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

endmodule

// File: tb/tb_cim_job_ctrl.sv
// Scoreboard bench for cim_job_ctrl with a behavioural CIM and result model.
module tb_cim_job_ctrl;
  import cim_pkg::*;

  localparam int unsigned RF_DEPTH = 4;
  localparam int unsigned LEN_W    = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_valid, cfg_ready;
  logic [VEC_W-1:0] cfg_weight;
  logic [LEN_W-1:0] cfg_len;
  logic             ifm_valid, ifm_ready;
  logic [VEC_W-1:0] ifm_data;
  logic             cim_weight_valid, cim_in_valid;
  logic [VEC_W-1:0] cim_Weight, cim_IFM;
  logic             cim_out_valid = 1'b0;
  logic [OFM_W-1:0] cim_OFM = '0;
  logic             res_valid, res_last, busy, done, err;
  logic             res_ready = 1'b1;
  logic [OFM_W-1:0] res_data;

  always #5 clk = ~clk;

  cim_job_ctrl #(
    .CIM_LAT (1),
    .RF_DEPTH(RF_DEPTH),
    .LEN_W   (LEN_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_weight      (cfg_weight),
    .cfg_len         (cfg_len),
    .ifm_valid       (ifm_valid),
    .ifm_ready       (ifm_ready),
    .ifm_data        (ifm_data),
    .cim_weight_valid(cim_weight_valid),
    .cim_Weight      (cim_Weight),
    .cim_in_valid    (cim_in_valid),
    .cim_IFM         (cim_IFM),
    .cim_out_valid   (cim_out_valid),
    .cim_OFM         (cim_OFM),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_data        (res_data),
    .res_last        (res_last),
    .busy            (busy),
    .done            (done),
    .err             (err)
  );

  typedef struct {
    logic [OFM_W-1:0] data;
    logic             last;
  } exp_t;

  exp_t             exp_q[$];
  logic [VEC_W-1:0] vecs[$];
  int               checks = 0, failures = 0, cyc = 0;
  int               job_len = 0, in_cnt = 0, wv_cnt = 0, since_last = 0, acc_cyc = 0;
  int               done_cnt = 0;
  logic [VEC_W-1:0] job_w = '0;
  logic             job_active = 1'b0, rv_seen = 1'b0, exp_err = 1'b0;
  logic             rr_rand = 1'b0, rr_fixed = 1'b1, spur = 1'b0;

  task automatic check(input string name, input logic [VEC_W-1:0] act,
                       input logic [VEC_W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference MAC: plain sum of lane products.
  function automatic logic [OFM_W-1:0] dot(input logic [VEC_W-1:0] w,
                                           input logic [VEC_W-1:0] x);
    int s = 0;
    for (int l = 0; l < N_LANE; l++) begin
      s += int'(w[l*W_BITS +: W_BITS]) * int'(x[l*W_BITS +: W_BITS]);
    end
    return OFM_W'(s);
  endfunction

  function automatic logic [VEC_W-1:0] rand_vec();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural CIM core, one cycle of latency.
  logic             cap_v = 1'b0;
  logic [OFM_W-1:0] cap_r = '0;
  always @(negedge clk) begin
    cap_v = rst_n && cim_in_valid;
    cap_r = dot(cim_Weight, cim_IFM);
  end
  always @(posedge clk) begin
    #1;
    cim_out_valid = cap_v || spur;
    cim_OFM       = cap_r;
  end

  always @(posedge clk) begin
    #1;
    res_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_fixed;
  end

  // Monitor: input mirroring, scoreboard pops and job-completion checks.
  logic             pend_hs = 1'b0;
  logic [VEC_W-1:0] pend_data = '0;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      pend_hs = 1'b0;
    end else begin
      if (pend_hs) begin
        check("cim_in_valid after handshake", cim_in_valid, 1);
        check("cim_IFM", cim_IFM, pend_data);
        check("cim_Weight", cim_Weight, job_w);
      end else begin
        check("cim_in_valid without handshake", cim_in_valid, 0);
      end
      pend_hs   = ifm_valid && ifm_ready;
      pend_data = ifm_data;
      if (cim_in_valid) in_cnt++;
      if (cim_weight_valid) wv_cnt++;
      if (res_valid) rv_seen = 1'b1;
      check("busy", busy, job_active);
      since_last++;
      if (cfg_valid && cfg_ready) acc_cyc = cyc;
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected result: got %0d expected none", res_data);
        end else begin
          e = exp_q.pop_front();
          check("res_data", res_data, e.data);
          check("res_last", res_last, e.last);
        end
        if (res_last) since_last = 0;
      end
      if (done) begin
        check("queue empty at done", exp_q.size(), 0);
        check("cim_in_valid count", in_cnt, job_len);
        check("cim_weight_valid pulses", wv_cnt, 1);
        if (job_len == 0) begin
          check("zero-length done latency", cyc - acc_cyc, 3);
          check("zero-length res_valid seen", rv_seen, 0);
        end else begin
          check("done one cycle after last pop", since_last, 1);
        end
        job_active = 1'b0;
        done_cnt++;
      end
    end
  end

  task automatic start_job(input logic [VEC_W-1:0] w, input int len);
    job_w   = w;
    job_len = len;
    @(posedge clk);
    #1;
    cfg_valid  = 1'b1;
    cfg_weight = w;
    cfg_len    = LEN_W'(len);
    @(negedge clk);
    check("cfg_ready in idle", cfg_ready, 1);
    @(posedge clk);
    job_active = 1'b1;
    in_cnt     = 0;
    wv_cnt     = 0;
    rv_seen    = 1'b0;
    since_last = 0;
    #1 cfg_valid = 1'b0;
  endtask

  task automatic feed(input int mode);
    int i = 0;
    int t = 0;
    while (i < job_len && t < 3000) begin
      @(posedge clk);
      #1;
      case (mode)
        0:       ifm_valid = 1'b1;
        1:       ifm_valid = (t % 2 == 0);
        default: ifm_valid = 1'($urandom_range(0, 1));
      endcase
      ifm_data = vecs[i];
      @(negedge clk);
      if (ifm_valid && ifm_ready) begin
        exp_q.push_back('{data: dot(job_w, vecs[i]), last: (i == job_len - 1)});
        i++;
      end
      t++;
    end
    if (i < job_len) begin
      checks++;
      failures++;
      $display("FAIL feed timeout: got %0d vectors accepted expected %0d", i, job_len);
    end
    @(posedge clk);
    #1 ifm_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == start) begin
      checks++;
      failures++;
      $display("FAIL done timeout: got no done in %0d cycles expected done", budget);
      job_active = 1'b0;
    end
  endtask

  task automatic run_job(input logic [VEC_W-1:0] w, input int len, input int mode);
    start_job(w, len);
    fork
      feed(mode);
      wait_done(400);
    join
    check("err after job", err, exp_err);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VEC_W-1:0] w;
    int hs, t;
    rst_n = 1'b0;
    cfg_valid = 1'b0;
    cfg_weight = '0;
    cfg_len = '0;
    ifm_valid = 1'b0;
    ifm_data = '0;
    #1;
    check("reset cfg_ready", cfg_ready, 1);
    check("reset busy", busy, 0);
    check("reset res_valid", res_valid, 0);
    check("reset err", err, 0);
    check("reset cim_weight_valid", cim_weight_valid, 0);
    check("reset ifm_ready", ifm_ready, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Basic job: 32 lanes of 1*2 gives 64 per result.
    vecs.delete();
    for (int i = 0; i < 3; i++) vecs.push_back({N_LANE{4'd2}});
    run_job({N_LANE{4'd1}}, 3, 0);

    // Backpressure: credits stop issue at the FIFO depth.
    rr_fixed = 1'b0;
    vecs.delete();
    for (int i = 0; i < 10; i++) vecs.push_back(rand_vec());
    start_job(rand_vec(), 10);
    fork
      feed(0);
      begin
        repeat (25) @(negedge clk);
        check("backpressure issued", in_cnt, RF_DEPTH);
        check("backpressure ifm_ready", ifm_ready, 0);
        rr_fixed = 1'b1;
        wait_done(400);
      end
    join
    check("err after backpressure", err, 0);

    // Zero length.
    vecs.delete();
    run_job(rand_vec(), 0, 0);

    // Bubbly input with distinct values 1..5.
    vecs.delete();
    for (int i = 0; i < 5; i++) vecs.push_back({N_LANE{W_BITS'(i + 1)}});
    run_job(rand_vec(), 5, 1);

    // Randomised jobs with random valid/ready patterns.
    rr_rand = 1'b1;
    for (int j = 0; j < 8; j++) begin
      int len = $urandom_range(0, 12);
      vecs.delete();
      for (int i = 0; i < len; i++) vecs.push_back(rand_vec());
      run_job(rand_vec(), len, 2);
    end
    rr_rand  = 1'b0;
    rr_fixed = 1'b1;

    // Spurious return while idle.
    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    repeat (2) @(negedge clk);
    check("spurious err set", err, 1);
    check("spurious fifo empty", res_valid, 0);
    exp_err = 1'b1;
    repeat (5) @(negedge clk);
    check("spurious err sticky", err, 1);
    vecs.delete();
    for (int i = 0; i < 2; i++) vecs.push_back(rand_vec());
    run_job(rand_vec(), 2, 0);

    // Reset during streaming with two vectors issued.
    rr_fixed = 1'b0;
    w = rand_vec();
    vecs.delete();
    for (int i = 0; i < 6; i++) vecs.push_back(rand_vec());
    start_job(w, 6);
    hs = 0;
    t  = 0;
    while (hs < 2 && t < 100) begin
      @(posedge clk);
      #1;
      ifm_valid = 1'b1;
      ifm_data  = vecs[hs];
      @(negedge clk);
      if (ifm_valid && ifm_ready) begin
        exp_q.push_back('{data: dot(job_w, vecs[hs]), last: 1'b0});
        hs++;
      end
      t++;
    end
    check("mid-job handshakes", hs, 2);
    @(posedge clk);
    #2;
    rst_n      = 1'b0;
    job_active = 1'b0;
    #1;
    check("mid reset cfg_ready", cfg_ready, 1);
    check("mid reset busy", busy, 0);
    check("mid reset cim_in_valid", cim_in_valid, 0);
    check("mid reset cim_IFM", cim_IFM, 0);
    check("mid reset cim_Weight", cim_Weight, 0);
    check("mid reset ifm_ready", ifm_ready, 0);
    check("mid reset res_valid", res_valid, 0);
    check("mid reset res_data", res_data, 0);
    check("mid reset done", done, 0);
    check("mid reset err", err, 0);
    ifm_valid = 1'b0;
    exp_q.delete();
    exp_err = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n    = 1'b1;
    rr_fixed = 1'b1;
    vecs.delete();
    vecs.push_back(rand_vec());
    run_job(rand_vec(), 1, 0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
